fetch_pc_unit: RTL and testbench
================================

FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC loaded on reset.
REQ-002 Parameter EXC_VECTOR, default 32'h0000_0080, is the misaligned-redirect trap target (used only under REQ-031).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  hazard unit request to hold PC.
REQ-006 branch_taken  input  1  resolved taken branch; redirect to branch_target.
REQ-007 branch_target  input  32  branch destination byte address.
REQ-008 jump  input  1  jump redirect to jump_target.
REQ-009 jump_target  input  32  jump destination byte address.
REQ-010 halt  input  1  decoded halt instruction on the fetch path.
REQ-011 PC  output  32  current fetch address (registered).
REQ-012 PC_plus4  output  32  PC + 4, combinational, modulo 2^32.
REQ-013 if_valid  output  1  PC holds a fetch to be issued this cycle.
REQ-014 flush  output  1  combinational; clear IF/ID this cycle due to redirect.
REQ-015 halted  output  1  unit is in HALT state.
REQ-016 fetch_count  output  32  issued-fetch counter.
REQ-017 align_err  output  1  sticky misaligned-redirect flag.

Function
REQ-018 FSM states BOOT, RUN, HALT; BOOT->RUN unconditionally after one cycle; RUN->HALT on halt with no redirect; HALT exits only via rst.
REQ-019 if_valid = 1 only in RUN; halted = 1 only in HALT.
REQ-020 In RUN, next-PC priority: branch_taken (branch_target) > jump (jump_target) > stall (hold) > sequential (PC_plus4).
REQ-021 Redirect wins over a simultaneous stall; flush = 1 in any RUN cycle where branch_taken or jump is high, else 0.
REQ-022 halt in the same cycle as a redirect is ignored; redirect is taken, state stays RUN.
REQ-023 Redirect latency one cycle: target appears on PC at the edge following the request.
REQ-024 In BOOT and HALT, PC holds, flush = 0, and branch_taken/jump/stall/halt are ignored.
REQ-025 Sequential increment wraps 32'hFFFF_FFFC -> 32'h0000_0000 without error.
REQ-026 fetch_count increments by 1 on every RUN cycle where PC changes or a redirect is taken (not on stall-only cycles), saturating at 32'hFFFF_FFFF.
REQ-027 align_err, once set, stays 1 until rst.

Reset
REQ-028 On rst at a clock edge: PC = RESET_PC, state = BOOT, fetch_count = 0, align_err = 0; applies in any state, including mid-stall or HALT.
REQ-029 While rst is high, if_valid = 0, flush = 0, halted = 0.
REQ-030 rst dominates all other inputs in the same cycle.

Configuration
REQ-031 With macro PC_ALIGN_CHECK_EN defined: a redirect whose selected target[1:0] != 2'b00 loads EXC_VECTOR into PC, sets align_err, and still asserts flush.
REQ-032 Without PC_ALIGN_CHECK_EN: the selected target is loaded with bits [1:0] forced to 2'b00, and align_err is constant 0; the port exists in both builds.

Verification
REQ-033 rst high 2 cycles, then low 5 cycles -> PC = 0 in BOOT cycle, then 0x4, 0x8, 0xC, 0x10; fetch_count = 4; if_valid 0 in BOOT, 1 after.
REQ-034 Running at PC 0x10, stall high 3 cycles -> PC holds 0x10 for 3 cycles, fetch_count unchanged, then resumes 0x14.
REQ-035 At PC 0x20, stall=1, branch_taken=1, branch_target=0x100, jump=1, jump_target=0x200 same cycle -> flush=1 that cycle, next PC = 0x100.
REQ-036 At PC 0x40, halt=1 -> halted=1 next cycle, PC frozen at 0x40 for 10 cycles despite jump pulses; rst returns PC to 0, halted 0.
REQ-037 Jump to 0x102: with PC_ALIGN_CHECK_EN -> PC = 0x80, align_err = 1 sticky; without -> PC = 0x100, align_err = 0.
REQ-038 Jump to 0xFFFF_FFF8, run 3 cycles -> PC 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: program counter, redirect and halt control for the fetch stage.
// Optional build macro PC_ALIGN_CHECK_EN: when it is defined, a misaligned redirect
// target traps to EXC_VECTOR and sets the sticky align_err flag. When it is not
// defined, the low two bits of the target are dropped and align_err stays 0.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        halt,
  output logic [31:0] PC,
  output logic [31:0] PC_plus4,
  output logic        if_valid,
  output logic        flush,
  output logic        halted,
  output logic [31:0] fetch_count,
  output logic        align_err
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_nxt;
  logic [31:0] tgt;
  logic [31:0] tgt_ld;
  logic        tgt_bad;
  logic        redirect;
  logic        cnt_inc;

  assign PC_plus4 = PC + 32'd4;

  // A redirect is acted on only while running; branch outranks jump.
  assign redirect = (state == RUN) && (branch_taken || jump);
  assign tgt      = branch_taken ? branch_target : jump_target;
  assign tgt_ld   = tgt & ~32'd3;

`ifdef PC_ALIGN_CHECK_EN
  assign tgt_bad = |tgt[1:0];
`else
  assign tgt_bad = 1'b0;
`endif

  // These outputs are gated by rst so they drop in the same cycle reset is raised.
  assign if_valid = !rst && (state == RUN);
  assign halted   = !rst && (state == HALT);
  assign flush    = !rst && redirect;

  // Next state and next PC. Priority is redirect, then halt, then stall, then sequential fetch.
  always_comb begin
    state_nxt = state;
    pc_nxt    = PC;
    cnt_inc   = 1'b0;
    case (state)
      BOOT: state_nxt = RUN;
      RUN: begin
        if (redirect) begin
          pc_nxt  = tgt_bad ? EXC_VECTOR : tgt_ld;
          cnt_inc = 1'b1;
        end else if (halt) begin
          state_nxt = HALT;
        end else if (!stall) begin
          pc_nxt  = PC_plus4;
          cnt_inc = 1'b1;
        end
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = BOOT;
    endcase
  end

  // State, PC and saturating fetch counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      PC          <= RESET_PC;
      fetch_count <= '0;
    end else begin
      state <= state_nxt;
      PC    <= pc_nxt;
      if (cnt_inc && (fetch_count != 32'hFFFF_FFFF))
        fetch_count <= fetch_count + 32'd1;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  // Sticky misaligned-redirect flag. Only reset clears it.
  always_ff @(posedge clk) begin
    if (rst)                      align_err <= 1'b0;
    else if (redirect && tgt_bad) align_err <= 1'b1;
  end
`else
  assign align_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Table-driven bench for fetch_pc_unit with a queue scoreboard, followed by a randomized run checked against a reference model.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst, stall, branch_taken, jump, halt;
  logic [31:0] branch_target, jump_target;
  logic [31:0] PC, PC_plus4, fetch_count;
  logic        if_valid, flush, halted, align_err;

  fetch_pc_unit dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .halt(halt),
    .PC(PC), .PC_plus4(PC_plus4), .if_valid(if_valid), .flush(flush),
    .halted(halted), .fetch_count(fetch_count), .align_err(align_err)
  );

  always #5 clk = ~clk;

`ifdef PC_ALIGN_CHECK_EN
  localparam logic        AE  = 1'b1;
  localparam logic [31:0] JPC = 32'h0000_0080;
`else
  localparam logic        AE  = 1'b0;
  localparam logic [31:0] JPC = 32'h0000_0100;
`endif

  typedef struct {
    logic        rst, stall, br, jmp, hlt;
    logic [31:0] bt, jt;
    logic [31:0] pc, cnt;
    logic        fl, vl, hd, ae;
  } vec_t;

  typedef struct {
    logic [31:0] pc, cnt;
    logic        fl, vl, hd, ae;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic add(input logic r, input logic s, input logic b, input logic [31:0] bt,
                     input logic j, input logic [31:0] jt, input logic h,
                     input logic [31:0] pc, input logic fl, input logic vl, input logic hd,
                     input logic [31:0] cnt, input logic ae);
    vec_t v;
    v.rst = r; v.stall = s; v.br = b; v.bt = bt; v.jmp = j; v.jt = jt; v.hlt = h;
    v.pc = pc; v.fl = fl; v.vl = vl; v.hd = hd; v.cnt = cnt; v.ae = ae;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
    end
  endtask

  // At each step, inputs are driven at negedge, expected outputs are pushed to the scoreboard, and the comparison happens at negedge+1 before the next rising edge.
  task automatic drive(input logic r, input logic s, input logic b, input logic [31:0] bt,
                       input logic j, input logic [31:0] jt, input logic h, input exp_t e);
    @(negedge clk);
    rst = r; stall = s; branch_taken = b; branch_target = bt;
    jump = j; jump_target = jt; halt = h;
    sb.push_back(e);
  endtask

  task automatic sample(input int idx);
    exp_t e;
    #1;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard step %0d: got empty queue expected one entry", idx);
    end else begin
      e = sb.pop_front();
      chk("pc",       idx, PC,                 e.pc);
      chk("pc_plus4", idx, PC_plus4,           e.pc + 32'd4);
      chk("count",    idx, fetch_count,        e.cnt);
      chk("flush",    idx, {31'd0, flush},     {31'd0, e.fl});
      chk("if_valid", idx, {31'd0, if_valid},  {31'd0, e.vl});
      chk("halted",   idx, {31'd0, halted},    {31'd0, e.hd});
      chk("align",    idx, {31'd0, align_err}, {31'd0, e.ae});
    end
  endtask

  initial begin
    exp_t        e;
    logic [31:0] m_pc, m_cnt;
    logic        s, b;
    logic [31:0] bt;

    rst = 1'b1; stall = 0; branch_taken = 0; jump = 0; halt = 0;
    branch_target = 0; jump_target = 0;

    //  rst stall br bt          jmp jt            hlt  pc            fl vl hd cnt ae
    add(1, 0, 0, 0,            0, 0,            0,   32'h0,        0, 0, 0, 0,  0);  // 0 second reset cycle
    add(0, 0, 0, 0,            0, 0,            0,   32'h0,        0, 0, 0, 0,  0);  // 1 BOOT
    add(0, 0, 0, 0,            0, 0,            0,   32'h0,        0, 1, 0, 0,  0);  // 2 RUN
    add(0, 0, 0, 0,            0, 0,            0,   32'h4,        0, 1, 0, 1,  0);
    add(0, 0, 0, 0,            0, 0,            0,   32'h8,        0, 1, 0, 2,  0);
    add(0, 0, 0, 0,            0, 0,            0,   32'hC,        0, 1, 0, 3,  0);
    add(0, 1, 0, 0,            0, 0,            0,   32'h10,       0, 1, 0, 4,  0);  // 6 stall x3
    add(0, 1, 0, 0,            0, 0,            0,   32'h10,       0, 1, 0, 4,  0);
    add(0, 1, 0, 0,            0, 0,            0,   32'h10,       0, 1, 0, 4,  0);
    add(0, 0, 0, 0,            0, 0,            0,   32'h10,       0, 1, 0, 4,  0);
    add(0, 0, 0, 0,            0, 0,            0,   32'h14,       0, 1, 0, 5,  0);
    add(0, 0, 0, 0,            0, 0,            0,   32'h18,       0, 1, 0, 6,  0);
    add(0, 0, 0, 0,            0, 0,            0,   32'h1C,       0, 1, 0, 7,  0);
    add(0, 1, 1, 32'h100,      1, 32'h200,      0,   32'h20,       1, 1, 0, 8,  0);  // 13 branch beats jump and stall
    add(0, 0, 0, 0,            1, 32'h40,       0,   32'h100,      1, 1, 0, 9,  0);
    add(0, 0, 0, 0,            0, 0,            1,   32'h40,       0, 1, 0, 10, 0);  // 15 halt
    for (int i = 0; i < 9; i++)                                                      // HALT ignores every input
      add(0, i[0], i[1], 32'h300, ~i[0], 32'h200, 1, 32'h40, 0, 0, 1, 10, 0);
    add(1, 0, 0, 0,            1, 32'h200,      0,   32'h40,       0, 0, 0, 10, 0);  // 25 reset out of HALT
    add(0, 0, 0, 0,            0, 0,            0,   32'h0,        0, 0, 0, 0,  0);
    add(0, 0, 0, 0,            1, 32'h102,      0,   32'h0,        1, 1, 0, 0,  0);  // 27 misaligned jump
    add(0, 0, 0, 0,            1, 32'hFFFF_FFF8,0,   JPC,          1, 1, 0, 1,  AE);
    add(0, 0, 0, 0,            0, 0,            0,   32'hFFFF_FFF8,0, 1, 0, 2,  AE);
    add(0, 0, 0, 0,            0, 0,            0,   32'hFFFF_FFFC,0, 1, 0, 3,  AE);
    add(0, 0, 0, 0,            0, 0,            0,   32'h0,        0, 1, 0, 4,  AE);  // 31 wrapped
    add(0, 0, 1, 32'h300,      0, 0,            1,   32'h4,        1, 1, 0, 5,  AE);  // 32 halt ignored under redirect
    add(0, 1, 0, 0,            0, 0,            1,   32'h300,      0, 1, 0, 6,  AE);  // 33 halt beats stall
    add(0, 0, 0, 0,            0, 0,            0,   32'h300,      0, 0, 1, 6,  AE);
    add(1, 1, 0, 0,            0, 0,            0,   32'h300,      0, 0, 0, 6,  AE);  // 35 reset with stall held
    add(0, 1, 1, 32'h500,      1, 32'h600,      1,   32'h0,        0, 0, 0, 0,  0);  // 36 BOOT ignores inputs
    add(0, 0, 0, 0,            0, 0,            0,   32'h0,        0, 1, 0, 0,  0);
    add(0, 0, 0, 0,            0, 0,            0,   32'h4,        0, 1, 0, 1,  0);

    @(posedge clk);  // the first edge applies reset, the table starts on the next one
    foreach (tbl[i]) begin
      e.pc = tbl[i].pc; e.cnt = tbl[i].cnt; e.fl = tbl[i].fl;
      e.vl = tbl[i].vl; e.hd = tbl[i].hd;   e.ae = tbl[i].ae;
      drive(tbl[i].rst, tbl[i].stall, tbl[i].br, tbl[i].bt,
            tbl[i].jmp, tbl[i].jt, tbl[i].hlt, e);
      sample(i);
    end

    // Randomized stall/branch run against a small reference model. The table leaves the unit running at PC 8 with a count of 2.
    m_pc = 32'h8; m_cnt = 32'd2;
    for (int k = 0; k < 40; k++) begin
      s  = 1'($urandom_range(0, 1));
      b  = ($urandom_range(0, 4) == 0);
      bt = {$urandom, 2'b00} >> 2 << 2;
      e.pc = m_pc; e.cnt = m_cnt; e.fl = b; e.vl = 1'b1; e.hd = 1'b0; e.ae = 1'b0;
      drive(0, s, b, bt, 0, 0, 0, e);
      sample(100 + k);
      if (b)       begin m_pc = bt;          m_cnt++; end
      else if (!s) begin m_pc = m_pc + 32'd4; m_cnt++; end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Safety net: a stuck run still reports and stops.
  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1);
  end

endmodule
